// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization tree root: request/response
// structs, the pending-barrier table entry and the error-cause enum.
package fractal_sync_pkg;

    localparam int AGGREGATE_WIDTH = 1;
    localparam int ID_WIDTH        = 5;
    localparam int SRC_WIDTH       = 2;
    localparam int N_PORTS         = 2;

    typedef struct packed {
        logic                       sync;
        logic [AGGREGATE_WIDTH-1:0] aggr;
        logic [ID_WIDTH-1:0]        id_req;
        logic [SRC_WIDTH-1:0]       src;
    } fsync_req_t;

    typedef struct packed {
        logic                 wake;
        logic [SRC_WIDTH-1:0] dst;
        logic                 error;
    } fsync_rsp_t;

    // One pending root barrier: which ports have arrived and their sources
    typedef struct packed {
        logic                              valid;
        logic [ID_WIDTH-1:0]               id;
        logic [N_PORTS-1:0]                arrived;
        logic [N_PORTS-1:0][SRC_WIDTH-1:0] src;
    } table_entry_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_AGGR,
        ERR_DUP,
        ERR_FULL
    } err_cause_e;

endpackage

// File: rtl/fractal_sync_root_table.sv
// Pending-barrier table of the root responder: merges same-ID requests,
// looks them up in a small CAM, allocates/completes entries and produces up
// to two response pushes per port per cycle (error first, then completions).
module fractal_sync_root_table
    import fractal_sync_pkg::*;
#(
    parameter int N_ENTRIES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  fsync_req_t         req_i [N_PORTS],
    output logic [N_PORTS-1:0] push0_valid,
    output fsync_rsp_t         push0_data [N_PORTS],
    output logic [N_PORTS-1:0] push1_valid,
    output fsync_rsp_t         push1_data [N_PORTS],
    output logic               busy_o
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [AGGREGATE_WIDTH-1:0] AGGR_ROOT = AGGREGATE_WIDTH'(1);

    table_entry_t          tbl_reg  [N_ENTRIES];
    table_entry_t          tbl_next [N_ENTRIES];
    err_cause_e            cause    [N_PORTS];
    logic                  merge_all;
    logic                  merge_hit;
    logic                  direct_cmp;
    logic                  push_lost;
    logic                  found;
    logic [IDX_W-1:0]      idx;
    fsync_rsp_t            rsp;

    // Classify every request, update the table and collect response pushes
    always_comb begin
        for (int e = 0; e < N_ENTRIES; e++) tbl_next[e] = tbl_reg[e];
        for (int p = 0; p < N_PORTS; p++) begin
            cause[p]      = ERR_NONE;
            push0_data[p] = '0;
            push1_data[p] = '0;
        end
        push0_valid = '0;
        push1_valid = '0;
        push_lost   = 1'b0;
        found       = 1'b0;
        idx         = '0;
        rsp         = '0;

        // All ports asking for the same unknown ID complete without a table entry
        merge_all = 1'b1;
        for (int p = 0; p < N_PORTS; p++) begin
            if (!req_i[p].sync || req_i[p].aggr != AGGR_ROOT ||
                req_i[p].id_req != req_i[0].id_req) merge_all = 1'b0;
        end
        merge_hit = 1'b0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (tbl_reg[e].valid && tbl_reg[e].id == req_i[0].id_req) merge_hit = 1'b1;
        end
        direct_cmp = merge_all && !merge_hit;

        // Ports are walked in index order against the evolving table, so a
        // higher port with the same ID merges into the entry a lower port just
        // allocated. Entries freed this cycle stay occupied until the edge.
        for (int p = 0; p < N_PORTS; p++) begin
            if (req_i[p].sync) begin
                if (req_i[p].aggr != AGGR_ROOT) begin
                    cause[p] = ERR_AGGR;
                end else if (!direct_cmp) begin
                    found = 1'b0;
                    idx   = '0;
                    for (int e = 0; e < N_ENTRIES; e++) begin
                        if (!found && tbl_next[e].valid && tbl_next[e].id == req_i[p].id_req) begin
                            found = 1'b1;
                            idx   = IDX_W'(e);
                        end
                    end
                    if (found) begin
                        if (tbl_next[idx].arrived[p]) begin
                            cause[p] = ERR_DUP;
                        end else begin
                            tbl_next[idx].arrived[p] = 1'b1;
                            tbl_next[idx].src[p]     = req_i[p].src;
                        end
                    end else begin
                        for (int e = 0; e < N_ENTRIES; e++) begin
                            if (!found && !tbl_next[e].valid) begin
                                found = 1'b1;
                                idx   = IDX_W'(e);
                            end
                        end
                        if (found) begin
                            tbl_next[idx]            = '0;
                            tbl_next[idx].valid      = 1'b1;
                            tbl_next[idx].id         = req_i[p].id_req;
                            tbl_next[idx].arrived[p] = 1'b1;
                            tbl_next[idx].src[p]     = req_i[p].src;
                        end else begin
                            cause[p] = ERR_FULL;
                        end
                    end
                end
            end
        end

        // Errors always occupy the first push slot of their port
        for (int p = 0; p < N_PORTS; p++) begin
            if (cause[p] != ERR_NONE) begin
                push0_valid[p] = 1'b1;
                push0_data[p]  = '{wake: 1'b1, dst: req_i[p].src, error: 1'b1};
            end
        end

        // Barrier completed entirely within this cycle
        if (direct_cmp) begin
            for (int p = 0; p < N_PORTS; p++) begin
                rsp = '{wake: 1'b1, dst: req_i[p].src, error: 1'b0};
                if (!push0_valid[p]) begin
                    push0_valid[p] = 1'b1;
                    push0_data[p]  = rsp;
                end else if (!push1_valid[p]) begin
                    push1_valid[p] = 1'b1;
                    push1_data[p]  = rsp;
                end else begin
                    push_lost = 1'b1;
                end
            end
        end

        // Completed table entries wake every port and are freed at this edge
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (tbl_next[e].valid && (&tbl_next[e].arrived)) begin
                for (int p = 0; p < N_PORTS; p++) begin
                    rsp = '{wake: 1'b1, dst: tbl_next[e].src[p], error: 1'b0};
                    if (!push0_valid[p]) begin
                        push0_valid[p] = 1'b1;
                        push0_data[p]  = rsp;
                    end else if (!push1_valid[p]) begin
                        push1_valid[p] = 1'b1;
                        push1_data[p]  = rsp;
                    end else begin
                        push_lost = 1'b1;
                    end
                end
                tbl_next[e] = '0;
            end
        end
    end

    // Table state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < N_ENTRIES; e++) tbl_reg[e] <= '0;
        end else begin
            for (int e = 0; e < N_ENTRIES; e++) tbl_reg[e] <= tbl_next[e];
        end
    end

    // Busy whenever any barrier is pending
    always_comb begin
        busy_o = 1'b0;
        for (int e = 0; e < N_ENTRIES; e++) busy_o = busy_o | tbl_reg[e].valid;
    end

    // One request per port per cycle bounds the pushes per port to two
    assert property (@(posedge clk_i) disable iff (!rst_ni) !push_lost);

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cov
        cover property (@(posedge clk_i) disable iff (!rst_ni) cause[gi] == ERR_AGGR);
        cover property (@(posedge clk_i) disable iff (!rst_ni) cause[gi] == ERR_DUP);
        cover property (@(posedge clk_i) disable iff (!rst_ni) cause[gi] == ERR_FULL);
    end

endmodule

// File: rtl/fractal_sync_root.sv
// Root responder of the fractal synchronization tree. Terminates the top
// node's request ports and returns one wake/error response per request
// through a 2-write/1-read FIFO per port feeding a registered output.
module fractal_sync_root
    import fractal_sync_pkg::*;
#(
    parameter int N_ENTRIES      = 4,
    parameter int RSP_FIFO_DEPTH = N_ENTRIES + 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  fsync_req_t req_i [N_PORTS],
    output fsync_rsp_t rsp_o [N_PORTS],
    output logic       busy_o,
    output logic       overflow_o
);

    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    logic [N_PORTS-1:0] push0_valid;
    logic [N_PORTS-1:0] push1_valid;
    fsync_rsp_t         push0_data [N_PORTS];
    fsync_rsp_t         push1_data [N_PORTS];
    logic [N_PORTS-1:0] drop_vec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    fractal_sync_root_table #(
        .N_ENTRIES (N_ENTRIES)
    ) u_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .push0_valid (push0_valid),
        .push0_data  (push0_data),
        .push1_valid (push1_valid),
        .push1_data  (push1_data),
        .busy_o      (busy_o)
    );

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        fsync_rsp_t       mem [RSP_FIFO_DEPTH];
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [CNT_W-1:0] cnt_reg;
        fsync_rsp_t       rsp_reg;
        logic             pop;
        logic             bypass;
        logic             wr_a_valid;
        logic             wr_b_valid;
        logic             wr_a_ok;
        logic             wr_b_ok;
        logic             drop;
        fsync_rsp_t       wr_a_data;
        fsync_rsp_t       wr_b_data;
        int               free_slots;

        // Decide pop/bypass and which pushes land in storage this cycle;
        // with an empty FIFO the first push goes straight to the output
        always_comb begin
            pop    = (cnt_reg != '0);
            bypass = !pop && push0_valid[gi];
            if (bypass) begin
                wr_a_valid = push1_valid[gi];
                wr_a_data  = push1_data[gi];
                wr_b_valid = 1'b0;
                wr_b_data  = '0;
            end else begin
                wr_a_valid = push0_valid[gi];
                wr_a_data  = push0_data[gi];
                wr_b_valid = push1_valid[gi];
                wr_b_data  = push1_data[gi];
            end
            free_slots = RSP_FIFO_DEPTH - int'(cnt_reg) + (pop ? 1 : 0);
            wr_a_ok    = wr_a_valid && (free_slots >= 1);
            wr_b_ok    = wr_b_valid && (free_slots >= 2);
            drop       = (wr_a_valid && !wr_a_ok) || (wr_b_valid && !wr_b_ok);
        end

        // Output register, pointers and occupancy; wake drops when idle
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                cnt_reg    <= '0;
                rsp_reg    <= '0;
            end else begin
                if (pop) begin
                    rsp_reg    <= mem[rd_ptr_reg];
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                end else if (bypass) begin
                    rsp_reg <= push0_data[gi];
                end else begin
                    rsp_reg.wake <= 1'b0;
                end
                if (wr_a_ok && wr_b_ok) begin
                    wr_ptr_reg <= ptr_inc(ptr_inc(wr_ptr_reg));
                end else if (wr_a_ok) begin
                    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                end
                cnt_reg <= cnt_reg - CNT_W'(pop) + CNT_W'(wr_a_ok) + CNT_W'(wr_b_ok);
            end
        end

        // FIFO storage, written in push order (error before completion)
        always_ff @(posedge clk_i) begin
            if (wr_a_ok) mem[wr_ptr_reg] <= wr_a_data;
            if (wr_b_ok) mem[ptr_inc(wr_ptr_reg)] <= wr_b_data;
        end

        assign rsp_o[gi]    = rsp_reg;
        assign drop_vec[gi] = drop;
    end

    // Sticky overflow flag for undersized FIFO configurations
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else if (|drop_vec) begin
            overflow_o <= 1'b1;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow_o);

endmodule
